// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_reg
// Purpose  : Elastic inter-stage register with valid/ready handshake and an
//            optional 2-entry skid buffer; flush turns held entries into bubbles.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
   parameter int DATA_W = 101,
   parameter int CTRL_W = 6,
   parameter int SKID   = 1
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [1:0]        occupancy
);

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_BUSY  = 2'd1,
      S_FULL  = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [DATA_W-1:0]   r_main_data;
   logic [DATA_W-1:0]   w_main_data_nxt;
   logic [CTRL_W-1:0]   r_main_ctrl;
   logic [CTRL_W-1:0]   w_main_ctrl_nxt;
   logic [DATA_W-1:0]   w_skid_data;
   logic [CTRL_W-1:0]   w_skid_ctrl;
   logic                w_skid_load;
   logic                w_skid_clr;
   logic                w_in_fire;
   logic                w_out_fire;

   assign out_valid  = (r_state != S_EMPTY);
   assign out_data   = r_main_data;
   assign out_ctrl   = r_main_ctrl;
   assign occupancy  = r_state;
   assign w_in_fire  = in_valid & in_ready;
   assign w_out_fire = out_valid & out_ready;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_state     <= S_EMPTY;
         r_main_data <= '0;
         r_main_ctrl <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_main_data <= w_main_data_nxt;
         r_main_ctrl <= w_main_ctrl_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_main_data_nxt = r_main_data;
      w_main_ctrl_nxt = r_main_ctrl;
      w_skid_load     = 1'b0;
      w_skid_clr      = 1'b0;
      // A flushed out_fire needs no action: the consumer already took it.
      if (flush) begin
         w_state_nxt     = S_EMPTY;
         w_main_ctrl_nxt = '0;
         w_skid_clr      = 1'b1;
      end else begin
         case (r_state)
            S_EMPTY: begin
               if (w_in_fire) begin
                  w_state_nxt     = S_BUSY;
                  w_main_data_nxt = in_data;
                  w_main_ctrl_nxt = in_ctrl;
               end
            end
            S_BUSY: begin
               if (w_in_fire && w_out_fire) begin
                  w_main_data_nxt = in_data;
                  w_main_ctrl_nxt = in_ctrl;
               end else if (w_in_fire) begin
                  if (SKID != 0) begin
                     w_state_nxt = S_FULL;
                     w_skid_load = 1'b1;
                  end
               end else if (w_out_fire) begin
                  w_state_nxt     = S_EMPTY;
                  w_main_ctrl_nxt = '0;
               end
            end
            S_FULL: begin
               if (w_out_fire) begin
                  w_state_nxt     = S_BUSY;
                  w_main_data_nxt = w_skid_data;
                  w_main_ctrl_nxt = w_skid_ctrl;
                  w_skid_clr      = 1'b1;
               end
            end
            default: begin
               w_state_nxt     = S_EMPTY;
               w_main_ctrl_nxt = '0;
            end
         endcase
      end
   end

   generate
      if (SKID != 0) begin : g_skid
         logic [DATA_W-1:0] r_skid_data;
         logic [CTRL_W-1:0] r_skid_ctrl;

         always_ff @(posedge CLK or negedge nRST) begin
            if (!nRST) begin
               r_skid_data <= '0;
               r_skid_ctrl <= '0;
            end else if (w_skid_load) begin
               r_skid_data <= in_data;
               r_skid_ctrl <= in_ctrl;
            end else if (w_skid_clr) begin
               r_skid_ctrl <= '0;
            end
         end

         assign w_skid_data = r_skid_data;
         assign w_skid_ctrl = r_skid_ctrl;
         // Pure state decode keeps out_ready off the upstream ready path.
         assign in_ready    = (r_state != S_FULL);
      end else begin : g_no_skid
         logic w_unused_skid;
         assign w_unused_skid = w_skid_load | w_skid_clr;
         assign w_skid_data   = '0;
         assign w_skid_ctrl   = '0;
         assign in_ready      = !out_valid | out_ready;
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_reg
// Purpose  : Self-checking bench for pipe_stage_reg in skid and non-skid modes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

   localparam int DW = 101;
   localparam int CW = 6;

   typedef struct {
      logic fl, iv, ordy, eir, eov;
      int   d, c, ed, ec, eocc;
   } vec_t;

   typedef struct {
      logic [DW-1:0] d;
      logic [CW-1:0] c;
   } ent_t;

   logic          CLK, nRST, fl, iv, ordy;
   logic [DW-1:0] idata;
   logic [CW-1:0] ictrl;
   logic          s1_ir, s1_ov, s0_ir, s0_ov;
   logic [DW-1:0] s1_od, s0_od;
   logic [CW-1:0] s1_oc, s0_oc;
   logic [1:0]    s1_occ, s0_occ;

   int   n_total = 0;
   int   n_pass  = 0;
   vec_t vecs[16];
   ent_t q[2][$];

   pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1)) u_skid1 (
      .CLK(CLK), .nRST(nRST), .flush(fl),
      .in_valid(iv), .in_ready(s1_ir), .in_data(idata), .in_ctrl(ictrl),
      .out_valid(s1_ov), .out_ready(ordy), .out_data(s1_od), .out_ctrl(s1_oc),
      .occupancy(s1_occ)
   );

   pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0)) u_skid0 (
      .CLK(CLK), .nRST(nRST), .flush(fl),
      .in_valid(iv), .in_ready(s0_ir), .in_data(idata), .in_ctrl(ictrl),
      .out_valid(s0_ov), .out_ready(ordy), .out_data(s0_od), .out_ctrl(s0_oc),
      .occupancy(s0_occ)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic vec_t mk(input logic fl_i, iv_i, input int d_i, c_i, input logic or_i,
                               input logic eir_i, eov_i, input int ed_i, ec_i, eocc_i);
      vec_t v;
      v.fl = fl_i; v.iv = iv_i; v.d = d_i; v.c = c_i; v.ordy = or_i;
      v.eir = eir_i; v.eov = eov_i; v.ed = ed_i; v.ec = ec_i; v.eocc = eocc_i;
      return v;
   endfunction

   // Compares one DUT against its queue model, then advances the model by this cycle's handshakes.
   task automatic sb_step(input int m, input logic ir, input logic ov, input logic [DW-1:0] od,
                          input logic [CW-1:0] oc, input logic [1:0] occ);
      int            sz;
      logic          e_ir;
      logic [127:0]  act, exp;
      ent_t          e;
      sz   = q[m].size();
      e_ir = (m == 1) ? (sz < 2) : ((sz == 0) || ordy);
      e.d  = '0;
      e.c  = '0;
      if (sz != 0) e = q[m][0];
      act = 128'({ir, ov, occ, (ov ? od : {DW{1'b0}}), oc});
      exp = 128'({e_ir, (sz != 0), 2'(sz), e.d, e.c});
      chk($sformatf("sb%0d", m), act, exp);
      if (sz != 0 && ordy) void'(q[m].pop_front());
      if (fl) q[m].delete();
      else if (iv && e_ir) begin
         e.d = idata;
         e.c = ictrl;
         q[m].push_back(e);
      end
   endtask

   initial begin
      logic [127:0] r128;

      vecs[0]  = mk(0, 1, 'h1,  1,   1, 1, 0, 0,     0,   0);
      vecs[1]  = mk(0, 1, 'h2,  2,   1, 1, 1, 'h1,  1,   1);
      vecs[2]  = mk(0, 1, 'h3,  3,   1, 1, 1, 'h2,  2,   1);
      vecs[3]  = mk(0, 1, 'h4,  4,   1, 1, 1, 'h3,  3,   1);
      vecs[4]  = mk(0, 0, 0,    0,   1, 1, 1, 'h4,  4,   1);
      vecs[5]  = mk(0, 1, 'hA,  'hA, 0, 1, 0, 0,     0,   0);
      vecs[6]  = mk(0, 1, 'hB,  'hB, 0, 1, 1, 'hA,  'hA, 1);
      vecs[7]  = mk(0, 1, 'hC,  'hC, 0, 0, 1, 'hA,  'hA, 2);
      vecs[8]  = mk(0, 0, 0,    0,   1, 0, 1, 'hA,  'hA, 2);
      vecs[9]  = mk(0, 0, 0,    0,   1, 1, 1, 'hB,  'hB, 1);
      vecs[10] = mk(0, 1, 'h11, 8,   0, 1, 0, 0,     0,   0);
      vecs[11] = mk(0, 1, 'h22, 8,   0, 1, 1, 'h11, 8,   1);
      vecs[12] = mk(1, 1, 'h33, 8,   0, 0, 1, 'h11, 8,   2);
      vecs[13] = mk(0, 1, 'h44, 8,   0, 1, 0, 0,     0,   0);
      vecs[14] = mk(1, 1, 'h55, 8,   1, 1, 1, 'h44, 8,   1);
      vecs[15] = mk(0, 0, 0,    0,   1, 1, 0, 0,     0,   0);

      nRST = 1'b0; fl = 1'b0; iv = 1'b0; ordy = 1'b0; idata = '0; ictrl = '0;
      #3;
      chk("reset_s1", 128'({s1_ir, s1_ov, s1_occ, s1_od, s1_oc}), 128'({1'b1, 1'b0, 2'd0, {DW{1'b0}}, 6'd0}));
      chk("reset_s0", 128'({s0_ir, s0_ov, s0_occ, s0_od, s0_oc}), 128'({1'b1, 1'b0, 2'd0, {DW{1'b0}}, 6'd0}));
      @(posedge CLK); @(posedge CLK); #1;
      nRST = 1'b1;

      for (int i = 0; i < 16; i++) begin
         fl = vecs[i].fl; iv = vecs[i].iv; idata = DW'(vecs[i].d);
         ictrl = CW'(vecs[i].c); ordy = vecs[i].ordy;
         @(negedge CLK);
         chk($sformatf("vec%0d.in_ready", i),  128'(s1_ir),  128'(vecs[i].eir));
         chk($sformatf("vec%0d.out_valid", i), 128'(s1_ov),  128'(vecs[i].eov));
         chk($sformatf("vec%0d.out_ctrl", i),  128'(s1_oc),  128'(vecs[i].ec));
         chk($sformatf("vec%0d.occupancy", i), 128'(s1_occ), 128'(vecs[i].eocc));
         if (vecs[i].eov) chk($sformatf("vec%0d.out_data", i), 128'(s1_od), 128'(vecs[i].ed));
         @(posedge CLK); #1;
      end
      fl = 1'b0;

      // Asynchronous reset while the skid stage is full.
      iv = 1'b1; ordy = 1'b0; idata = DW'(5); ictrl = 6'b001000;
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      iv = 1'b0;
      #1;
      chk("pre_rst_full", 128'(s1_occ), 128'(2));
      nRST = 1'b0;
      #1;
      chk("async_rst", 128'({s1_ir, s1_ov, s1_occ, s1_oc}), 128'({1'b1, 1'b0, 2'd0, 6'd0}));
      @(posedge CLK); #1;
      nRST = 1'b1;
      iv = 1'b1; idata = DW'('h1234); ictrl = '0;
      @(negedge CLK);
      chk("post_rst_ready", 128'(s1_ir), 128'(1));
      @(posedge CLK); #1;
      iv = 1'b0;
      @(negedge CLK);
      chk("post_rst_data", 128'({s1_ov, s1_od}), 128'({1'b1, DW'('h1234)}));
      @(posedge CLK); #1;
      ordy = 1'b1;
      @(posedge CLK); #1;
      ordy = 1'b0;

      // Non-skid mode: in_ready follows out_ready in the same cycle.
      iv = 1'b1; idata = DW'('h77); ictrl = 6'd1;
      @(negedge CLK);
      chk("s0_empty_ready", 128'(s0_ir), 128'(1));
      @(posedge CLK); #1;
      idata = DW'('h88); ictrl = 6'd2;
      @(negedge CLK);
      chk("s0_stall_ready", 128'(s0_ir), 128'(0));
      chk("s0_stall_data", 128'(s0_od), 128'(DW'('h77)));
      #2;
      ordy = 1'b1;
      #1;
      chk("s0_comb_ready", 128'(s0_ir), 128'(1));
      @(posedge CLK); #1;
      iv = 1'b0; ordy = 1'b0;
      @(negedge CLK);
      chk("s0_new_data", 128'({s0_ov, s0_od, s0_oc}), 128'({1'b1, DW'('h88), 6'd2}));
      @(posedge CLK); #1;
      fl = 1'b1;
      @(posedge CLK); #1;
      fl = 1'b0;

      for (int c = 0; c < 10000; c++) begin
         r128  = {$urandom, $urandom, $urandom, $urandom};
         fl    = ($urandom_range(31) == 0);
         iv    = ($urandom_range(3) != 0);
         ordy  = (c < 5000) ? ($urandom_range(1) == 0) : ($urandom_range(3) != 0);
         idata = r128[DW-1:0];
         ictrl = CW'($urandom_range(63));
         @(negedge CLK);
         sb_step(1, s1_ir, s1_ov, s1_od, s1_oc, s1_occ);
         sb_step(0, s0_ir, s0_ov, s0_od, s0_oc, s0_occ);
         @(posedge CLK); #1;
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised elastic pipeline stage register for the five-stage core.
- Successor to the fixed-field inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a data bus and a control bus with a valid/ready handshake, and provides an optional 2-entry skid buffer.
- Synchronous flush converts held entries into bubbles whose control bits are zero, so a flushed entry can never cause a regWEN or memory write.

Parameters:
- DATA_W, 101, width of the payload bus (PCs, ALU result, load data, register indices); not cleared on flush.
- CTRL_W, 6, width of the control bus (MemToReg, JType, RegDst, regWEN, PcSrc, JReg, ...); zeroed on flush and whenever an entry is empty.
- SKID, 1, 1 = registered in_ready with 2-entry skid buffer; 0 = single entry with combinational in_ready.

Ports:
- CLK, input, 1, clock; all state updates on the rising edge.
- nRST, input, 1, asynchronous active-low reset.
- flush, input, 1, synchronous squash of all held and incoming entries.
- in_valid, input, 1, upstream stage presents an entry.
- in_ready, output, 1, stage can accept an entry this cycle.
- in_data, input, DATA_W, incoming payload.
- in_ctrl, input, CTRL_W, incoming control bits.
- out_valid, output, 1, the main entry is valid.
- out_ready, input, 1, downstream stage consumes the entry this cycle.
- out_data, output, DATA_W, main register payload (registered).
- out_ctrl, output, CTRL_W, main register control (registered); 0 whenever out_valid=0.
- occupancy, output, 2, number of held entries: 0, 1 or 2.

Behaviour:
- Reset: nRST low asynchronously forces state EMPTY and clears main and skid data/ctrl to 0.
  - Outputs under reset: out_valid=0, out_data=0, out_ctrl=0, occupancy=0.
  - in_ready=1 under reset in both modes.
- Handshakes:
  - Accept: in_fire = in_valid & in_ready.
  - Consume: out_fire = out_valid & out_ready.
  - in_data/in_ctrl are sampled only on in_fire.
  - Latency: an entry accepted at edge N appears on out_* after edge N.
- State machine, SKID=1 (in_ready = state != FULL; a registered decode with no combinational path from out_ready):
  - EMPTY:
    - in_fire -> BUSY, main <= in.
    - otherwise stay.
  - BUSY:
    - in_fire & out_fire -> BUSY, main <= in.
    - in_fire & !out_fire -> FULL, skid <= in, main held.
    - !in_fire & out_fire -> EMPTY, main ctrl <= 0.
    - neither -> hold.
  - FULL:
    - out_fire -> BUSY, main <= skid, skid ctrl <= 0.
    - otherwise hold.
    - in_valid is ignored in FULL (in_ready=0).
- SKID=0:
  - in_ready = !out_valid | out_ready (combinational).
  - FULL is unreachable and skid logic is not instantiated.
  - Transitions are the same as EMPTY/BUSY above.
- Ordering: strict FIFO. The skid entry is always older than any later accept and is never overtaken.
- Flush:
  - Highest priority after reset.
  - Next state is EMPTY; main ctrl and skid ctrl are set to 0; data registers hold their values.
  - An in_fire in the flush cycle is discarded.
  - An out_fire in the flush cycle still completes, because the downstream stage already sampled it.
  - in_ready keeps its normal value during flush.
- Bubbles: out_ctrl is forced to 0 by register content (not by output gating) whenever out_valid=0.
- occupancy is 0 for EMPTY, 1 for BUSY, 2 for FULL; it is derived from the state register.
- Stall: downstream holding out_ready=0 keeps out_data/out_ctrl stable until out_fire (valid must not drop, data must not change).

Test Plan:
- Reset: nRST=0 mid-stream while in FULL.
  - Required: out_valid=0, out_ctrl=0, occupancy=0, in_ready=1 immediately (asynchronous).
  - Required after release: first accept of data=0x1234 appears on out_data one cycle later.
- Streaming, SKID=1: in_valid=1, out_ready=1, data 1,2,3,4 on consecutive cycles.
  - Required: out_data 1,2,3,4 on consecutive cycles, occupancy stays 1, in_ready stays 1.
- Backpressure, SKID=1: accept A=0xA, then hold out_ready=0 and present B=0xB.
  - Required: B accepted, occupancy=2, in_ready=0, out_data stays 0xA.
  - Then raise out_ready: outputs 0xA, then 0xB, in that order.
- Flush, SKID=1: in FULL with ctrl=6'b001000 (regWEN) in both entries, assert flush with in_valid=1.
  - Required next cycle: out_valid=0, out_ctrl=0, occupancy=0, incoming entry dropped.
- SKID=0 mode: out_valid=1, out_ready=0.
  - Required: in_ready=0 in the same cycle.
  - Raise out_ready with a new entry presented: in_ready=1 in the same cycle, new data on out_data after the edge.
- Random traffic: random in_valid/out_ready/flush over 10k cycles against a scoreboard.
  - Required: no loss or duplication except entries squashed by flush, FIFO order preserved, out_ctrl=0 whenever out_valid=0.
